// File: rtl/alu_pipe_harness.sv
// ALU timing harness: LFSR or external operands feed a 2-stage registered ALU;
// a run of ITER ops is sequenced by an FSM and results are folded into a MISR.
// Optional macro ALU_SWEEP_EN: op select comes from an internal {sel,mode}
// counter instead of sel_in/mode_in.
module alu_pipe_harness #(
  parameter int unsigned  N    = 64,
  parameter int unsigned  ITER = 16,
  parameter logic [N-1:0] POLY = 64'hD800000000000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N-1:0]               seed,
  input  logic                       ext,
  input  logic [N-1:0]               a_in,
  input  logic [N-1:0]               b_in,
  input  logic [2:0]                 sel_in,
  input  logic                       mode_in,
  output logic [N-1:0]               result,
  output logic [3:0]                 flags,
  output logic [N-1:0]               signature,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ITER+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(ITER + 1);
  localparam int unsigned SW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic           accept, issue;
  logic [N-1:0]   lfsr_a_q, lfsr_b_q;
  logic [N-1:0]   seed_a, seed_b;
  logic [N-1:0]   op_a_q, op_b_q;
  logic [2:0]     sel_q;
  logic           mode_q;
  logic           v1_q, v2_q;
  logic [N-1:0]   result_q;
  logic [3:0]     flags_q;
  logic [N-1:0]   sig_q;
  logic [CW-1:0]  count_q;
  logic [2:0]     issue_sel;
  logic           issue_mode;
  logic [N-1:0]   alu_res;
  logic           alu_c, alu_v;
  logic [N-1:0]   b_eff;
  logic [N:0]     sum;
  logic [SW-1:0]  sh;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // An all-zero LFSR would lock up, so a zero load becomes all-ones.
  assign seed_a = (seed == '0) ? '1 : seed;
  assign seed_b = (seed == '1) ? '1 : ~seed;

`ifdef ALU_SWEEP_EN
  logic [3:0] sweep_q;
  logic       unused_sel;
  assign unused_sel = ^{sel_in, mode_in};
  assign issue_sel  = sweep_q[3:1];
  assign issue_mode = sweep_q[0];

  // Sweep counter: restarts on accepted start, advances per issued op.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sweep_q <= 4'd0;
    end else if (accept) begin
      sweep_q <= 4'd0;
    end else if (issue) begin
      sweep_q <= sweep_q + 4'd1;
    end
  end
`else
  assign issue_sel  = sel_in;
  assign issue_mode = mode_in;
`endif

  // FSM next state plus accept/issue strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        issue = 1'b1;
        if (count_q == CW'(ITER - 1)) state_d = StDrain;
      end
      StDrain: begin
        if (v2_q && !v1_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register and issued-op counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q <= '0;
      end else if (issue) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  // Operand LFSRs: load on accepted start, step on every issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_a_q <= '0;
      lfsr_b_q <= '0;
    end else if (accept) begin
      lfsr_a_q <= seed_a;
      lfsr_b_q <= seed_b;
    end else if (issue) begin
      lfsr_a_q <= lfsr_step(lfsr_a_q);
      lfsr_b_q <= lfsr_step(lfsr_b_q);
    end
  end

  // Stage 1: capture operands and op select on issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
      sel_q  <= 3'd0;
      mode_q <= 1'b0;
      v1_q   <= 1'b0;
    end else if (accept) begin
      v1_q <= 1'b0;
    end else if (issue) begin
      op_a_q <= ext ? a_in : lfsr_a_q;
      op_b_q <= ext ? b_in : lfsr_b_q;
      sel_q  <= issue_sel;
      mode_q <= issue_mode;
      v1_q   <= 1'b1;
    end else begin
      v1_q <= 1'b0;
    end
  end

  // ALU combinational core; mode selects subtract or arithmetic shift.
  always_comb begin
    b_eff   = mode_q ? ~op_b_q : op_b_q;
    sum     = {1'b0, op_a_q} + {1'b0, b_eff} + {{N{1'b0}}, mode_q};
    sh      = op_b_q[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (sel_q)
      3'b000: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (op_a_q[N-1] == b_eff[N-1]) && (sum[N-1] != op_a_q[N-1]);
      end
      3'b001: alu_res = op_a_q & op_b_q;
      3'b010: alu_res = op_a_q | op_b_q;
      3'b011: alu_res = op_a_q ^ op_b_q;
      3'b100: alu_res = op_a_q << sh;
      3'b101: begin
        if (mode_q) alu_res = $signed(op_a_q) >>> sh;
        else        alu_res = op_a_q >> sh;
      end
      3'b110: alu_res = ~op_a_q;
      default: alu_res = op_a_q;
    endcase
  end

  // Stage 2: register result/flags only for valid ops so DONE holds them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= 4'd0;
      v2_q     <= 1'b0;
    end else if (accept) begin
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        result_q <= alu_res;
        flags_q  <= {alu_res[N-1], alu_v, alu_c, alu_res == '0};
      end
    end
  end

  // MISR: fold each valid stage-2 result into the signature.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= '0;
    end else if (v2_q) begin
      sig_q <= lfsr_step(sig_q) ^ result_q;
    end
  end

  assign result    = result_q;
  assign flags     = flags_q;
  assign signature = sig_q;
  assign count     = count_q;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_alu_pipe_harness.sv
// Self-checking bench for alu_pipe_harness at N=8, ITER=4.
module tb_alu_pipe_harness;

  localparam int          N    = 8;
  localparam int          ITER = 4;
  localparam logic [7:0]  POLY = 8'hB8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, ext, mode_in;
  logic [7:0] seed, a_in, b_in;
  logic [2:0] sel_in;
  logic [7:0] result, signature;
  logic [3:0] flags;
  logic       busy, done;
  logic [2:0] count;

  int passed = 0;
  int total  = 0;

  logic [7:0] obs[ITER];
  logic [7:0] exp_res[ITER];
  logic [3:0] exp_fl[ITER];
  logic [7:0] exp_sig;

  alu_pipe_harness #(.N(N), .ITER(ITER), .POLY(POLY)) dut (
    .clock(clk), .reset(rst_n), .start(start), .seed(seed), .ext(ext),
    .a_in(a_in), .b_in(b_in), .sel_in(sel_in), .mode_in(mode_in),
    .result(result), .flags(flags), .signature(signature),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr8(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Reference ALU from plain integer arithmetic.
  function automatic void alu_model(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] sel, input logic mode,
                                    output logic [7:0] r, output logic [3:0] f);
    int ua, ub, sa, sb, full, sr, tmp;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (sel)
      3'd0: begin
        if (!mode) begin full = ua + ub; c = (full > 255); sr = sa + sb; end
        else       begin full = ua - ub; c = (ua >= ub);   sr = sa - sb; end
        r = full[7:0];
        v = (sr > 127) || (sr < -128);
      end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a << b[2:0];
      3'd5: begin
        if (!mode) r = a >> b[2:0];
        else begin tmp = sa >>> b[2:0]; r = tmp[7:0]; end
      end
      3'd6: r = ~a;
      default: r = a;
    endcase
    f = {r[7], v, c, r == 8'h00};
  endfunction

  // One complete run with model checking; poke asserts start mid-RUN.
  task automatic do_run(input string name, input logic [7:0] seed_v, input logic ext_v,
                        input bit rand_ops, input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic [2:0] sel_v, input logic mode_v, input bit poke);
    logic [7:0] ra[ITER], rb[ITER];
    logic [2:0] rs[ITER];
    logic       rm[ITER];
    logic [7:0] la, lb, opa, opb;
    logic [2:0] s;
    logic       m;
    logic [3:0] sw;
    int         done_edge;
    bit         busy_bad;
    done_edge = -1;
    busy_bad  = 0;
    @(negedge clk);
    start = 1'b1; seed = seed_v; ext = ext_v;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== 3'd0) begin
      $display("FAIL %s start: busy/done/count got %b/%b/%0d want 1/0/0", name, busy, done, count);
    end else passed++;
    for (int e = 1; e <= ITER + 8; e++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && e == 2) begin start = 1'b1; seed = ~seed_v; end
      if (e <= ITER) begin
        if (rand_ops) begin
          a_in = 8'($urandom); b_in = 8'($urandom);
          sel_in = 3'($urandom); mode_in = 1'($urandom);
        end else begin
          a_in = a_v; b_in = b_v; sel_in = sel_v; mode_in = mode_v;
        end
        ra[e-1] = a_in; rb[e-1] = b_in; rs[e-1] = sel_in; rm[e-1] = mode_in;
      end
      @(posedge clk); #1;
      if (e >= 2 && e <= ITER + 1) obs[e-2] = result;
      if (done) begin done_edge = e; break; end
      if (!busy) busy_bad = 1;
    end
    start = 1'b0;
    // Model the run from the spec rules.
    la = (seed_v == 8'h00) ? 8'hFF : seed_v;
    lb = (~seed_v == 8'h00) ? 8'hFF : ~seed_v;
    exp_sig = 8'h00;
    for (int i = 0; i < ITER; i++) begin
      opa = ext_v ? ra[i] : la;
      opb = ext_v ? rb[i] : lb;
      la = lfsr8(la); lb = lfsr8(lb);
`ifdef ALU_SWEEP_EN
      sw = 4'(i); s = sw[3:1]; m = sw[0];
`else
      sw = 4'd0; s = rs[i]; m = rm[i];
`endif
      alu_model(opa, opb, s, m, exp_res[i], exp_fl[i]);
      exp_sig = lfsr8(exp_sig) ^ exp_res[i];
    end
    total++;
    if (done_edge !== ITER + 2) begin
      $display("FAIL %s done_edge: got %0d want %0d", name, done_edge, ITER + 2);
    end else passed++;
    total++;
    if (busy_bad) $display("FAIL %s busy: got 0 before done want 1", name);
    else passed++;
    for (int i = 0; i < ITER; i++) begin
      total++;
      if (obs[i] !== exp_res[i]) begin
        $display("FAIL %s result op%0d: got %h want %h", name, i, obs[i], exp_res[i]);
      end else passed++;
    end
    total++;
    if (flags !== exp_fl[ITER-1]) begin
      $display("FAIL %s flags: got %b want %b", name, flags, exp_fl[ITER-1]);
    end else passed++;
    total++;
    if (signature !== exp_sig || count !== 3'(ITER)) begin
      $display("FAIL %s sig/count: got %h/%0d want %h/%0d", name, signature, count, exp_sig, ITER);
    end else passed++;
    // DONE must hold everything while inputs wiggle.
    repeat (3) begin
      @(negedge clk);
      a_in = 8'($urandom); b_in = 8'($urandom); sel_in = 3'($urandom); mode_in = 1'($urandom);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b1 || result !== exp_res[ITER-1] || signature !== exp_sig) begin
      $display("FAIL %s hold: got done=%b res=%h sig=%h want 1/%h/%h",
               name, done, result, signature, exp_res[ITER-1], exp_sig);
    end else passed++;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (result !== 8'h00 || flags !== 4'h0 || signature !== 8'h00 || busy !== 1'b0 ||
        done !== 1'b0 || count !== 3'd0) begin
      $display("FAIL reset: got res=%h fl=%b sig=%h busy=%b done=%b cnt=%0d want all 0",
               result, flags, signature, busy, done, count);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    do_run("add_ff_01", 8'h5A, 1'b1, 0, 8'hFF, 8'h01, 3'b000, 1'b0, 0);
`ifndef ALU_SWEEP_EN
    total++;
    if (result !== 8'h00 || flags !== 4'b0011) begin
      $display("FAIL add_ff_01 const: got %h/%b want 00/0011", result, flags);
    end else passed++;
`endif
    do_run("sub_80_01", 8'h33, 1'b1, 0, 8'h80, 8'h01, 3'b000, 1'b1, 0);
`ifndef ALU_SWEEP_EN
    total++;
    if (result !== 8'h7F || flags !== 4'b0110) begin
      $display("FAIL sub_80_01 const: got %h/%b want 7F/0110", result, flags);
    end else passed++;
`endif
  endtask

  task automatic test_shifts();
    logic [2:0] sels[3];
    logic       modes[3];
    logic [7:0] want[3];
    logic [3:0] wfl[3];
    sels = '{3'b100, 3'b101, 3'b101};
    modes = '{1'b0, 1'b0, 1'b1};
    want = '{8'h08, 8'h10, 8'hF0};
    wfl = '{4'b0000, 4'b0000, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      do_run("shift", 8'h11, 1'b1, 0, 8'h81, 8'h03, sels[k], modes[k], 0);
`ifndef ALU_SWEEP_EN
      total++;
      if (result !== want[k] || flags !== wfl[k]) begin
        $display("FAIL shift%0d const: got %h/%b want %h/%b", k, result, flags, want[k], wfl[k]);
      end else passed++;
`endif
    end
  endtask

  task automatic test_random_runs();
    for (int k = 0; k < 6; k++) begin
      do_run("random", 8'($urandom), 1'(k % 2), 1, 8'h00, 8'h00, 3'd0, 1'b0, 0);
    end
  endtask

  task automatic test_start_in_run();
    do_run("start_in_run", 8'hC3, 1'b0, 1, 8'h00, 8'h00, 3'd0, 1'b0, 1);
  endtask

  task automatic test_seed_zero();
    do_run("seed_zero", 8'h00, 1'b0, 0, 8'h00, 8'h00, 3'b111, 1'b0, 0);
`ifndef ALU_SWEEP_EN
    total++;
    if (obs[0] !== 8'hFF || obs[1] !== 8'hC7) begin
      $display("FAIL seed_zero stream: got %h,%h want FF,C7", obs[0], obs[1]);
    end else passed++;
`endif
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start = 1'b1; seed = 8'h9D; ext = 1'b0; sel_in = 3'b111; mode_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (result !== 8'h00 || flags !== 4'h0 || signature !== 8'h00 || busy !== 1'b0 ||
        done !== 1'b0 || count !== 3'd0) begin
      $display("FAIL reset_midrun: got res=%h fl=%b sig=%h busy=%b done=%b cnt=%0d want all 0",
               result, flags, signature, busy, done, count);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_midrun idle: got busy=%b done=%b want 0/0", busy, done);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] sig1;
    do_run("repeat1", 8'h0F, 1'b1, 0, 8'h0F, 8'h03, 3'b010, 1'b0, 0);
    sig1 = signature;
    do_run("repeat2", 8'h0F, 1'b1, 0, 8'h0F, 8'h03, 3'b010, 1'b0, 0);
    total++;
    if (signature !== sig1) begin
      $display("FAIL repeat sig: got %h want %h", signature, sig1);
    end else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ext = 1'b0; mode_in = 1'b0;
    seed = 8'h00; a_in = 8'h00; b_in = 8'h00; sel_in = 3'd0;
    test_reset();
    test_add_sub();
    test_shifts();
    test_random_runs();
    test_start_in_run();
    test_seed_zero();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_pipe_harness.md
Name: alu_pipe_harness

Overview:
- Parametrised successor to the fixed-operand ALU timing harness.
- Operands come from two Galois LFSRs or from external ports, and pass through a 2-stage registered ALU pipeline.
- A programmable number of operations runs under an FSM; results are compressed into a MISR signature.
- Used for on-board timing closure and regression of ALU width N.

Parameters:
- N, 64, datapath width (N >= 4)
- ITER, 16, operations issued per run (>= 1)
- POLY, 64'hD800000000000000, Galois tap mask, N bits; must be set to match N (e.g. 8'hB8 for N=8)

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle run request; honoured in IDLE or DONE
- seed  in  N  LFSR seed, latched on accepted start
- ext  in  1  1 = operands from a_in/b_in, 0 = from LFSRs
- a_in  in  N  external operand A
- b_in  in  N  external operand B
- sel_in  in  3  ALU op select
- mode_in  in  1  op modifier (sub / arithmetic shift)
- result  out  N  registered ALU result
- flags  out  4  registered {negative, overflow, carry, zero}
- signature  out  N  MISR value
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- count  out  $clog2(ITER+1)  operations issued in current run

Behaviour:
- Reset (async, reset=0): FSM=IDLE; result, flags, signature, count, operand regs and valids = 0; busy = done = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: go RUN, clear count, signature, v1 and v2.
  - On that same accepted start: LFSR_A <= seed, LFSR_B <= ~seed; any zero seed value is replaced by all-ones.
  - RUN: each cycle issue one op: opA/opB <= ext ? a_in/b_in : LFSR_A/LFSR_B, capture sel/mode, v1 <= 1, both LFSRs step, count++.
  - RUN exits to DRAIN on the edge where count reaches ITER.
  - DRAIN: no issue, v1 <= 0; go DONE on the edge the last result is absorbed (v2=1, v1=0).
  - DONE: hold all outputs; done=1 until next start.
- start in RUN/DRAIN is ignored.
- LFSR step: s_next = s[0] ? (s>>1)^POLY : s>>1.
- Stage 2 (edge after issue): ALU on opA/opB; result and flags registered; v2 <= v1.
- ALU ops by sel:
  - 000: mode 0 gives A+B, mode 1 gives A-B. carry = bit N of the sum (sub: 1 = no borrow, A>=B unsigned). overflow = signed overflow.
  - 001: AND. 010: OR. 011: XOR.
  - 100: A << B[$clog2(N)-1:0].
  - 101: A >> B[$clog2(N)-1:0], logical when mode 0, arithmetic when mode 1.
  - 110: ~A. 111: A (pass).
  - Non-arith ops: carry = overflow = 0.
  - zero = (result == 0); negative = result[N-1].
- MISR: on edge with v2=1, sig <= (sig[0] ? (sig>>1)^POLY : sig>>1) ^ result.
- Latency: issue -> result 1 cycle; last MISR update ITER+2 edges after accepted start; done rises the same edge.
- Reset mid-run aborts immediately to IDLE with reset values; no partial done.

Optional Feature:
- Macro: ALU_SWEEP_EN.
- Defined: sel/mode captured at issue come from a 4-bit counter {sel,mode} that starts at 0 on accepted start and increments per issued op, wrapping 1111->0000; sel_in and mode_in are ignored.
- Undefined: sel_in and mode_in are used directly.

Test Plan:
- N=8, ext=1, a_in=FF, b_in=01, sel=000, mode=0 -> result 00, flags zero=1, carry=1, ovf=0, neg=0.
- N=8, ext=1, a_in=80, b_in=01, sel=000, mode=1 -> result 7F, ovf=1, carry=1, neg=0.
- N=8, a_in=81, b_in=03: sel=100 -> 08; sel=101 mode=0 -> 10; sel=101 mode=1 -> F0.
- N=8, ITER=4, start at edge 0 -> busy from edge 0; done=1 after edge 6; count=4; signature matches bench LFSR/MISR model; start during RUN has no effect.
- seed=0 -> LFSR_A loads FF and the run still produces a non-constant stream; reset low mid-RUN -> all outputs 0 and state IDLE asynchronously.
- ALU_SWEEP_EN defined, ITER=16, ext=1, a_in=0F, b_in=03 -> results follow sel/mode 0..15 order; two identical runs give identical signatures.
